// File: rtl/commit_checker_pkg.sv
// Shared types and constants for the commit-stream checker.
// Record kinds, expected/observed payload structs, err bit indices and the "no index" marker.
package commit_checker_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 3;
    localparam int unsigned ERR_W  = 3;
    localparam int unsigned SUB_W  = 4;

    localparam int unsigned ERR_MISMATCH = 0;
    localparam int unsigned ERR_OVERFLOW = 1;
    localparam int unsigned ERR_LEFTOVER = 2;

    localparam logic [DATA_W-1:0] NONE_IDX = 16'hFFFF;

    typedef enum logic [1:0] {
        KIND_REG   = 2'd0,
        KIND_LOAD  = 2'd1,
        KIND_STORE = 2'd2,
        KIND_HALT  = 2'd3
    } commitKindT;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_DONE = 2'd1,
        ST_STOP = 2'd2
    } checkStateT;

    typedef struct packed {
        commitKindT        kind;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } expRecT;

    // Flag order puts REG at bit 0 so the lowest pending flag is the next sub-event in trace order.
    typedef struct packed {
        logic              halt;
        logic              memWrite;
        logic              memRead;
        logic              regWrite;
        logic [REG_W-1:0]  writeRegister;
        logic [DATA_W-1:0] writeData;
        logic [DATA_W-1:0] memAddress;
        logic [DATA_W-1:0] memDataIn;
        logic [DATA_W-1:0] memDataOut;
    } obsCycleT;

    localparam int unsigned EXP_W = $bits(expRecT);
    localparam int unsigned OBS_W = $bits(obsCycleT);

    function automatic commitKindT kindOfSub(input logic [SUB_W-1:0] oneHot);
        commitKindT k;
        k = KIND_HALT;
        if (oneHot[0])      k = KIND_REG;
        else if (oneHot[1]) k = KIND_LOAD;
        else if (oneHot[2]) k = KIND_STORE;
        return k;
    endfunction

endpackage

// File: rtl/commit_checker_if.sv
// Golden-record load port plus processor commit strobes seen by the checker.
interface commit_checker_if;
    logic        exp_valid;
    logic        exp_ready;
    logic [1:0]  exp_kind;
    logic [15:0] exp_addr;
    logic [15:0] exp_data;

    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        Halt;
    logic [2:0]  WriteRegister;
    logic [15:0] WriteData;
    logic [15:0] MemAddress;
    logic [15:0] MemDataIn;
    logic [15:0] MemDataOut;

    modport master (
        output exp_valid, exp_kind, exp_addr, exp_data,
        output RegWrite, MemRead, MemWrite, Halt,
        output WriteRegister, WriteData, MemAddress, MemDataIn, MemDataOut,
        input  exp_ready
    );

    modport slave (
        input  exp_valid, exp_kind, exp_addr, exp_data,
        input  RegWrite, MemRead, MemWrite, Halt,
        input  WriteRegister, WriteData, MemAddress, MemDataIn, MemDataOut,
        output exp_ready
    );
endinterface

// File: rtl/commit_checker_fifo.sv
// checker_fifo: synchronous first-word-fall-through FIFO with registered full/empty/count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module checker_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         headC,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;
    logic [CW-1:0]    countNext;

    always_comb begin
        doPush    = push && (!full || pop);
        doPop     = pop && !empty;
        countNext = count + CW'(doPush) - CW'(doPop);
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            count <= countNext;
            full  <= (countNext == CW'(DEPTH));
            empty <= (countNext == '0);
        end
    end

    assign headC = mem[rdPtr];

endmodule

// File: rtl/commit_checker.sv
// commit_checker: compares a golden REG/LOAD/STORE/HALT record stream against live commit events.
// Build option COMMIT_CHECKER_STOP_ON_MISMATCH_EN freezes checking at the first mismatch.
module commit_checker
    import commit_checker_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    commit_checker_if.slave       bus,
    output logic                  done,
    output logic [ERR_W-1:0]      err,
    output logic [DATA_W-1:0]     match_count,
    output logic [DATA_W-1:0]     mismatch_count,
    output logic [DATA_W-1:0]     first_bad_idx
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    checkStateT       state;
    expRecT           expIn;
    expRecT           expHead;
    obsCycleT         obsIn;
    obsCycleT         obsHead;
    logic             expPush, expPop, expFull, expEmpty;
    logic             obsPush, obsPop, obsFull, obsEmpty;
    logic [CNT_W-1:0] expCount;
    logic [CNT_W-1:0] unusedObsCount;

    logic [SUB_W-1:0]  subDone;
    logic [SUB_W-1:0]  obsFlags;
    logic [SUB_W-1:0]  remaining;
    logic [SUB_W-1:0]  curSub;
    logic              lastSub;
    commitKindT        curKind;
    logic              fieldsOk;
    logic              isMatch;
    logic              cmpValid;
    logic [DATA_W-1:0] expIdx;

    assign bus.exp_ready = !expFull;

    // Input packing and FIFO handshakes; records offered after RUN are accepted and dropped.
    always_comb begin
        expIn.kind = commitKindT'(bus.exp_kind);
        expIn.addr = bus.exp_addr;
        expIn.data = bus.exp_data;

        obsIn.halt          = bus.Halt;
        obsIn.memWrite      = bus.MemWrite;
        obsIn.memRead       = bus.MemRead;
        obsIn.regWrite      = bus.RegWrite;
        obsIn.writeRegister = bus.WriteRegister;
        obsIn.writeData     = bus.WriteData;
        obsIn.memAddress    = bus.MemAddress;
        obsIn.memDataIn     = bus.MemDataIn;
        obsIn.memDataOut    = bus.MemDataOut;

        expPush = bus.exp_valid && !expFull && (state == ST_RUN);
        obsPush = (state == ST_RUN) &&
                  (bus.RegWrite || bus.MemRead || bus.MemWrite || bus.Halt);
    end

    // Pick the next pending sub-event of the observed head and compare it with the expected head.
    always_comb begin
        obsFlags  = {obsHead.halt, obsHead.memWrite, obsHead.memRead, obsHead.regWrite};
        remaining = obsFlags & ~subDone;
        curSub    = remaining & (~remaining + SUB_W'(1));
        lastSub   = ((remaining & ~curSub) == '0);
        curKind   = kindOfSub(curSub);

        fieldsOk = 1'b0;
        case (curKind)
            KIND_REG:   fieldsOk = (expHead.addr[REG_W-1:0] == obsHead.writeRegister) &&
                                   (expHead.data == obsHead.writeData);
            KIND_LOAD:  fieldsOk = (expHead.addr == obsHead.memAddress) &&
                                   (expHead.data == obsHead.memDataOut);
            KIND_STORE: fieldsOk = (expHead.addr == obsHead.memAddress) &&
                                   (expHead.data == obsHead.memDataIn);
            KIND_HALT:  fieldsOk = 1'b1;
            default:    fieldsOk = 1'b0;
        endcase

        isMatch  = (expHead.kind == curKind) && fieldsOk;
        cmpValid = (state == ST_RUN) && !obsEmpty && !expEmpty;
        expPop   = cmpValid || ((state == ST_DONE) && !expEmpty);
        obsPop   = cmpValid && lastSub;
    end

    checker_fifo #(.WIDTH(EXP_W), .DEPTH(DEPTH)) uExpFifo (
        .clk   (clk),
        .rst   (rst),
        .push  (expPush),
        .pop   (expPop),
        .din   (expIn),
        .headC (expHead),
        .full  (expFull),
        .empty (expEmpty),
        .count (expCount)
    );

    checker_fifo #(.WIDTH(OBS_W), .DEPTH(DEPTH)) uObsFifo (
        .clk   (clk),
        .rst   (rst),
        .push  (obsPush),
        .pop   (obsPop),
        .din   (obsIn),
        .headC (obsHead),
        .full  (obsFull),
        .empty (obsEmpty),
        .count (unusedObsCount)
    );

    // Compare FSM with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_RUN;
            subDone        <= '0;
            expIdx         <= '0;
            done           <= 1'b0;
            err            <= '0;
            match_count    <= '0;
            mismatch_count <= '0;
            first_bad_idx  <= NONE_IDX;
        end else begin
            if (obsPush && obsFull && !obsPop) err[ERR_OVERFLOW] <= 1'b1;

            if (cmpValid) begin
                expIdx  <= expIdx + DATA_W'(1);
                subDone <= lastSub ? '0 : (subDone | curSub);
                if (isMatch) begin
                    if (match_count != NONE_IDX) match_count <= match_count + DATA_W'(1);
                    if (curKind == KIND_HALT) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        if (expCount > CNT_W'(1)) err[ERR_LEFTOVER] <= 1'b1;
                    end
                end else begin
                    if (mismatch_count != NONE_IDX) mismatch_count <= mismatch_count + DATA_W'(1);
                    err[ERR_MISMATCH] <= 1'b1;
                    if (first_bad_idx == NONE_IDX) first_bad_idx <= expIdx;
`ifdef COMMIT_CHECKER_STOP_ON_MISMATCH_EN
                    state <= ST_STOP;
`else
                    state <= ST_RUN;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_commit_checker.sv
// Scoreboard bench for commit_checker: expected compare outcomes are queued as stimulus is driven
// and retired by a monitor watching the match/mismatch counters.
module tb_commit_checker;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    commit_checker_if bus();

    logic        done;
    logic [2:0]  err;
    logic [15:0] matchCount;
    logic [15:0] mismatchCount;
    logic [15:0] firstBadIdx;

    commit_checker #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .done           (done),
        .err            (err),
        .match_count    (matchCount),
        .mismatch_count (mismatchCount),
        .first_bad_idx  (firstBadIdx)
    );

    int tests = 0;
    int fails = 0;
    bit sbQ[$];
    logic [15:0] prevMatch = '0;
    logic [15:0] prevMis = '0;
    int obsRes;
    bit expRes;

    // Monitor: each counter step is one compare outcome, checked against the scoreboard head.
    always @(negedge clk) begin
        if (rst) begin
            prevMatch = '0;
            prevMis   = '0;
        end else if (matchCount !== prevMatch || mismatchCount !== prevMis) begin
            if (matchCount == prevMatch + 16'd1 && mismatchCount == prevMis) obsRes = 1;
            else if (mismatchCount == prevMis + 16'd1 && matchCount == prevMatch) obsRes = 0;
            else obsRes = 2;
            tests++;
            if (sbQ.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got outcome %0d, scoreboard empty", obsRes);
            end else begin
                expRes = sbQ.pop_front();
                if (obsRes !== int'(expRes)) begin
                    fails++;
                    $display("FAIL sb_outcome: got %0d expected %0d", obsRes, expRes);
                end
            end
            prevMatch = matchCount;
            prevMis   = mismatchCount;
        end
    end

    task automatic idle_inputs();
        bus.exp_valid = 1'b0; bus.exp_kind = 2'd0; bus.exp_addr = '0; bus.exp_data = '0;
        bus.RegWrite = 1'b0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.Halt = 1'b0;
        bus.WriteRegister = '0; bus.WriteData = '0; bus.MemAddress = '0;
        bus.MemDataIn = '0; bus.MemDataOut = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sbQ.delete();
    endtask

    task automatic load_exp(input logic [1:0] k, input logic [15:0] a, input logic [15:0] d);
        int budget;
        budget = 0;
        bus.exp_valid = 1'b1; bus.exp_kind = k; bus.exp_addr = a; bus.exp_data = d;
        while (!bus.exp_ready && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 100) begin
            tests++; fails++;
            $display("FAIL load_timeout: exp_ready stuck at %0b expected 1", bus.exp_ready);
        end
        @(posedge clk); #1;
        bus.exp_valid = 1'b0;
    endtask

    task automatic commit(input logic rw, input logic mr, input logic mw, input logic h,
                          input logic [2:0] wr, input logic [15:0] wd, input logic [15:0] ma,
                          input logic [15:0] mdi, input logic [15:0] mdo);
        bus.RegWrite = rw; bus.MemRead = mr; bus.MemWrite = mw; bus.Halt = h;
        bus.WriteRegister = wr; bus.WriteData = wd; bus.MemAddress = ma;
        bus.MemDataIn = mdi; bus.MemDataOut = mdo;
        @(posedge clk); #1;
        bus.RegWrite = 1'b0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.Halt = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int budget;
        budget = 0;
        while (sbQ.size() != 0 && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        tests++;
        if (sbQ.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d outcomes pending expected 0", name, sbQ.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        tests += 6;
        if (bus.exp_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %0b expected 1", bus.exp_ready); end
        if (done !== 1'b0) begin fails++; $display("FAIL rst_done: got %0b expected 0", done); end
        if (err !== 3'b000) begin fails++; $display("FAIL rst_err: got %0b expected 000", err); end
        if (matchCount !== 16'd0) begin fails++; $display("FAIL rst_match: got %0h expected 0", matchCount); end
        if (mismatchCount !== 16'd0) begin fails++; $display("FAIL rst_mismatch: got %0h expected 0", mismatchCount); end
        if (firstBadIdx !== 16'hFFFF) begin fails++; $display("FAIL rst_fbi: got %0h expected ffff", firstBadIdx); end
    endtask

    task automatic test_basic();
        apply_reset();
        load_exp(2'd0, 16'd3, 16'h00AB);
        load_exp(2'd2, 16'h0010, 16'h1234);
        load_exp(2'd3, 16'd0, 16'd0);
        sbQ.push_back(1'b1); sbQ.push_back(1'b1); sbQ.push_back(1'b1);
        commit(1, 0, 0, 0, 3'd3, 16'h00AB, 16'h0, 16'h0, 16'h0);
        @(posedge clk); #1;
        commit(0, 0, 1, 0, 3'd0, 16'h0, 16'h0010, 16'h1234, 16'h0);
        @(posedge clk); #1;
        commit(0, 0, 0, 1, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0);
        wait_drain("basic");
        tests += 4;
        if (matchCount !== 16'd3) begin fails++; $display("FAIL basic_match: got %0d expected 3", matchCount); end
        if (done !== 1'b1) begin fails++; $display("FAIL basic_done: got %0b expected 1", done); end
        if (err !== 3'b000) begin fails++; $display("FAIL basic_err: got %0b expected 000", err); end
        if (firstBadIdx !== 16'hFFFF) begin fails++; $display("FAIL basic_fbi: got %0h expected ffff", firstBadIdx); end
    endtask

    task automatic test_multi_sub();
        apply_reset();
        load_exp(2'd0, 16'd1, 16'h0005);
        load_exp(2'd1, 16'h0020, 16'h0005);
        sbQ.push_back(1'b1); sbQ.push_back(1'b1);
        commit(1, 1, 0, 0, 3'd1, 16'h0005, 16'h0020, 16'h0, 16'h0005);
        tests++;
        if (matchCount !== 16'd0) begin fails++; $display("FAIL multi_lat0: got %0d expected 0", matchCount); end
        @(posedge clk); #1;
        tests++;
        if (matchCount !== 16'd1) begin fails++; $display("FAIL multi_lat1: got %0d expected 1", matchCount); end
        @(posedge clk); #1;
        tests++;
        if (matchCount !== 16'd2) begin fails++; $display("FAIL multi_lat2: got %0d expected 2", matchCount); end
        wait_drain("multi");
    endtask

    task automatic test_mismatch();
        logic [15:0] expMatch;
        apply_reset();
        load_exp(2'd0, 16'd2, 16'h0001);
        sbQ.push_back(1'b0);
        commit(1, 0, 0, 0, 3'd2, 16'h0002, 16'h0, 16'h0, 16'h0);
        wait_drain("mis");
        tests += 3;
        if (mismatchCount !== 16'd1) begin fails++; $display("FAIL mis_count: got %0d expected 1", mismatchCount); end
        if (err[0] !== 1'b1) begin fails++; $display("FAIL mis_err0: got %0b expected 1", err[0]); end
        if (firstBadIdx !== 16'd0) begin fails++; $display("FAIL mis_fbi: got %0h expected 0", firstBadIdx); end
`ifdef COMMIT_CHECKER_STOP_ON_MISMATCH_EN
        expMatch = 16'd0;
`else
        expMatch = 16'd1;
        sbQ.push_back(1'b1);
`endif
        load_exp(2'd0, 16'd4, 16'h0007);
        commit(1, 0, 0, 0, 3'd4, 16'h0007, 16'h0, 16'h0, 16'h0);
        wait_drain("mis_after");
        tests += 3;
        if (matchCount !== expMatch) begin fails++; $display("FAIL mis_after_match: got %0d expected %0d", matchCount, expMatch); end
        if (mismatchCount !== 16'd1) begin fails++; $display("FAIL mis_after_count: got %0d expected 1", mismatchCount); end
        if (firstBadIdx !== 16'd0) begin fails++; $display("FAIL mis_after_fbi: got %0h expected 0", firstBadIdx); end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < int'(DEPTH) + 1; i++) begin
            bus.RegWrite = 1'b1; bus.WriteRegister = 3'(i % 8); bus.WriteData = 16'(32'h100 + i);
            @(posedge clk); #1;
        end
        bus.RegWrite = 1'b0;
        tests += 2;
        if (err[1] !== 1'b1) begin fails++; $display("FAIL ovf_err1: got %0b expected 1", err[1]); end
        if (err[0] !== 1'b0) begin fails++; $display("FAIL ovf_err0: got %0b expected 0", err[0]); end
        for (int i = 0; i < int'(DEPTH); i++) begin
            sbQ.push_back(1'b1);
            load_exp(2'd0, 16'(i % 8), 16'(32'h100 + i));
        end
        wait_drain("ovf");
        tests += 2;
        if (matchCount !== 16'(DEPTH)) begin fails++; $display("FAIL ovf_match: got %0d expected %0d", matchCount, DEPTH); end
        if (mismatchCount !== 16'd0) begin fails++; $display("FAIL ovf_mis: got %0d expected 0", mismatchCount); end
        load_exp(2'd0, 16'(DEPTH % 8), 16'(32'h100 + DEPTH));
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (matchCount !== 16'(DEPTH) || mismatchCount !== 16'd0) begin
            fails++;
            $display("FAIL ovf_dropped: got %0d/%0d expected %0d/0", matchCount, mismatchCount, DEPTH);
        end
    endtask

    task automatic test_halt_leftover();
        apply_reset();
        load_exp(2'd3, 16'd0, 16'd0);
        load_exp(2'd0, 16'd0, 16'd0);
        sbQ.push_back(1'b1);
        commit(0, 0, 0, 1, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0);
        wait_drain("halt");
        tests += 4;
        if (done !== 1'b1) begin fails++; $display("FAIL halt_done: got %0b expected 1", done); end
        if (err !== 3'b100) begin fails++; $display("FAIL halt_err: got %0b expected 100", err); end
        if (matchCount !== 16'd1) begin fails++; $display("FAIL halt_match: got %0d expected 1", matchCount); end
        if (bus.exp_ready !== 1'b1) begin fails++; $display("FAIL halt_ready: got %0b expected 1", bus.exp_ready); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        load_exp(2'd0, 16'd1, 16'h0001);
        load_exp(2'd1, 16'h0030, 16'h0002);
        load_exp(2'd2, 16'h0030, 16'h0003);
        sbQ.push_back(1'b1); sbQ.push_back(1'b1); sbQ.push_back(1'b1);
        commit(1, 1, 1, 0, 3'd1, 16'h0001, 16'h0030, 16'h0003, 16'h0002);
        @(posedge clk); #1;
        tests++;
        if (matchCount !== 16'd1) begin fails++; $display("FAIL mid_pre: got %0d expected 1", matchCount); end
        rst = 1'b1;
        #1;
        tests += 6;
        if (matchCount !== 16'd0) begin fails++; $display("FAIL mid_match: got %0d expected 0", matchCount); end
        if (mismatchCount !== 16'd0) begin fails++; $display("FAIL mid_mis: got %0d expected 0", mismatchCount); end
        if (done !== 1'b0) begin fails++; $display("FAIL mid_done: got %0b expected 0", done); end
        if (err !== 3'b000) begin fails++; $display("FAIL mid_err: got %0b expected 000", err); end
        if (firstBadIdx !== 16'hFFFF) begin fails++; $display("FAIL mid_fbi: got %0h expected ffff", firstBadIdx); end
        if (bus.exp_ready !== 1'b1) begin fails++; $display("FAIL mid_ready: got %0b expected 1", bus.exp_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        sbQ.delete();
        load_exp(2'd0, 16'd5, 16'h0055);
        sbQ.push_back(1'b1);
        commit(1, 0, 0, 0, 3'd5, 16'h0055, 16'h0, 16'h0, 16'h0);
        wait_drain("mid_fresh");
        tests += 2;
        if (matchCount !== 16'd1) begin fails++; $display("FAIL mid_fresh_match: got %0d expected 1", matchCount); end
        if (err !== 3'b000) begin fails++; $display("FAIL mid_fresh_err: got %0b expected 000", err); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_basic();
        test_multi_sub();
        test_mismatch();
        test_overflow();
        test_halt_leftover();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
